// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//   - CPU MEM-stage request side (cpu_*), with stall and tagged read return
//   - DMA/debug loader request side (dma_*), with grant and tagged read return
//   - DMEM port (SC/LC/Data_in/DMEMaddr/CS/DM_W/DM_R out, Dataout in)
//   slave  : view taken by the arbiter
//   master : view taken by the requesters and memory (e.g. a testbench)
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_SC;
  logic [2:0]  cpu_LC;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;

  logic        dma_req;
  logic        dma_we;
  logic [1:0]  dma_SC;
  logic [2:0]  dma_LC;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic [31:0] dma_rdata;
  logic        dma_rvalid;

  logic [1:0]  SC;
  logic [2:0]  LC;
  logic [31:0] Data_in;
  logic [31:0] DMEMaddr;
  logic        CS;
  logic        DM_W;
  logic        DM_R;
  logic [31:0] Dataout;

  modport slave (
    input  cpu_req, cpu_we, cpu_SC, cpu_LC, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_SC, dma_LC, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output SC, LC, Data_in, DMEMaddr, CS, DM_W, DM_R,
    input  Dataout
  );

  modport master (
    output cpu_req, cpu_we, cpu_SC, cpu_LC, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_SC, dma_LC, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  SC, LC, Data_in, DMEMaddr, CS, DM_W, DM_R,
    output Dataout
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single DMEM port between the CPU MEM stage and the DMA/debug
//   loader. CPU has fixed priority, except that a waiting DMA request is
//   forced through after STARVE_LIMIT consecutive CPU grants. Grants are
//   combinational (zero latency); read data is registered and returned one
//   cycle after the grant with an rvalid pulse on the owning side.
// Ports
//   clk    : system clock, all state on rising edge
//   reset  : synchronous, active-high
//   bus    : dmem_arbiter_if.slave (CPU side, DMA side, DMEM port)
// Parameters
//   STARVE_LIMIT : consecutive CPU grants tolerated while DMA waits (1..15)
//
// Read-return FSM
//   state   | meaning
//   IDLE    | no read return this cycle
//   RET_CPU | rd_buf holds CPU load data, cpu_rvalid high
//   RET_DMA | rd_buf holds DMA load data, dma_rvalid high
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RET_CPU = 2'd1,
    RET_DMA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  starve_cnt;
  logic [31:0] rd_buf;
  logic        dma_starved;
  logic        gnt_cpu;
  logic        gnt_dma;
  logic        rd_cpu;
  logic        rd_dma;

  // DMA wins only once it has watched LIMIT CPU grants go by.
  assign dma_starved = bus.dma_req & (starve_cnt == LIMIT);
  assign gnt_cpu     = bus.cpu_req & ~reset & ~dma_starved;
  assign gnt_dma     = bus.dma_req & ~reset & ~gnt_cpu;
  assign rd_cpu      = gnt_cpu & ~bus.cpu_we;
  assign rd_dma      = gnt_dma & ~bus.dma_we;

  always_comb begin
    bus.CS       = 1'b0;
    bus.DM_W     = 1'b0;
    bus.DM_R     = 1'b0;
    bus.SC       = 2'd0;
    bus.LC       = 3'd0;
    bus.DMEMaddr = 32'd0;
    bus.Data_in  = 32'd0;
    if (gnt_cpu) begin
      bus.CS       = 1'b1;
      bus.DM_W     = bus.cpu_we;
      bus.DM_R     = ~bus.cpu_we;
      bus.SC       = bus.cpu_SC;
      bus.LC       = bus.cpu_LC;
      bus.DMEMaddr = bus.cpu_addr;
      bus.Data_in  = bus.cpu_wdata;
    end else if (gnt_dma) begin
      bus.CS       = 1'b1;
      bus.DM_W     = bus.dma_we;
      bus.DM_R     = ~bus.dma_we;
      bus.SC       = bus.dma_SC;
      bus.LC       = bus.dma_LC;
      bus.DMEMaddr = bus.dma_addr;
      bus.Data_in  = bus.dma_wdata;
    end
  end

  assign bus.cpu_stall  = bus.cpu_req & ~gnt_cpu;
  assign bus.dma_gnt    = gnt_dma;
  assign bus.cpu_rvalid = (state == RET_CPU);
  assign bus.dma_rvalid = (state == RET_DMA);
  assign bus.cpu_rdata  = rd_buf;
  assign bus.dma_rdata  = rd_buf;

  // Any break in the DMA request restarts its full starvation budget.
  always_ff @(posedge clk) begin
    if (reset || !bus.dma_req || gnt_dma) begin
      starve_cnt <= 4'd0;
    end else if (gnt_cpu && starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      rd_buf <= 32'd0;
    end else begin
      state <= state_nxt;
      if (rd_cpu || rd_dma) begin
        rd_buf <= bus.Dataout;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    if (rd_cpu) begin
      state_nxt = RET_CPU;
    end else if (rd_dma) begin
      state_nxt = RET_DMA;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with STARVE_LIMIT = 4. A small
//   word-addressed DMEM model answers reads combinationally and commits
//   writes on the clock edge. Expected read returns are queued when a read
//   is expected to be granted and compared one cycle later.
module tb_dmem_arbiter;

  logic clk;
  logic reset;
  dmem_arbiter_if bus ();

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  assign bus.Dataout = mem[bus.DMEMaddr[7:2]];
  always @(posedge clk) begin
    if (bus.CS && bus.DM_W) mem[bus.DMEMaddr[7:2]] <= bus.Data_in;
  end

  typedef struct {
    bit          is_dma;
    logic [31:0] data;
  } ret_t;

  ret_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_SC    = 2'd0;
    bus.cpu_LC    = 3'd0;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_dma(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
    bus.dma_req   = req;
    bus.dma_we    = we;
    bus.dma_SC    = 2'd0;
    bus.dma_LC    = 3'd0;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h10, 32'd0);
    set_dma(1'b1, 1'b0, 32'h14, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_cmp++;
      if (bus.CS !== 1'b0 || bus.DM_W !== 1'b0 || bus.dma_gnt !== 1'b0 ||
          bus.cpu_stall !== 1'b1) begin
        n_err++;
        $display("FAIL reset_outputs c=%0d: CS=%b DM_W=%b dma_gnt=%b cpu_stall=%b, required 0 0 0 1",
                 c, bus.CS, bus.DM_W, bus.dma_gnt, bus.cpu_stall);
      end
      n_cmp++;
      if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_rvalid c=%0d: cpu_rvalid=%b dma_rvalid=%b, required 0 0",
                 c, bus.cpu_rvalid, bus.dma_rvalid);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rdata !== 32'd0 || bus.CS !== 1'b0 || bus.cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: cpu_rdata=%h CS=%b cpu_rvalid=%b, required 00000000 0 0",
               bus.cpu_rdata, bus.CS, bus.cpu_rvalid);
    end
  endtask

  task automatic test_cpu_load();
    ret_t r;
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.CS !== 1'b1 || bus.DM_R !== 1'b1 || bus.DM_W !== 1'b0 ||
        bus.DMEMaddr !== 32'h10 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_load_issue: CS=%b DM_R=%b DM_W=%b addr=%h stall=%b, required 1 1 0 00000010 0",
               bus.CS, bus.DM_R, bus.DM_W, bus.DMEMaddr, bus.cpu_stall);
    end
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    r = sb.pop_front();
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== r.data || bus.dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_load_return: cpu_rvalid=%b cpu_rdata=%h dma_rvalid=%b, required 1 %h 0",
               bus.cpu_rvalid, bus.cpu_rdata, bus.dma_rvalid, r.data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL cpu_load_pulse: cpu_rvalid=%b, required 0", bus.cpu_rvalid);
    end
  endtask

  // Both sides load every cycle; expected DMA grant cycles come from a table.
  task automatic test_contention();
    ret_t r;
    bit   exp_dma;
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b0, 32'h40, 32'd0);
    set_dma(1'b1, 1'b0, 32'h44, 32'd0);
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 10) begin
          set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
          set_dma(1'b0, 1'b0, 32'd0, 32'd0);
        end
      end
      @(negedge clk);
      n_cmp++;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        if (bus.cpu_rvalid !== !r.is_dma || bus.dma_rvalid !== r.is_dma ||
            (r.is_dma ? bus.dma_rdata : bus.cpu_rdata) !== r.data) begin
          n_err++;
          $display("FAIL contend_return c=%0d: cpu_rvalid=%b dma_rvalid=%b rdata=%h, required dma=%b data=%h",
                   c, bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, r.is_dma, r.data);
        end
      end else if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL contend_return c=%0d: cpu_rvalid=%b dma_rvalid=%b, required 0 0",
                 c, bus.cpu_rvalid, bus.dma_rvalid);
      end
      if (c < 10) begin
        exp_dma = (c == 4) || (c == 9);
        n_cmp++;
        if (bus.cpu_stall !== exp_dma || bus.dma_gnt !== exp_dma ||
            bus.DMEMaddr !== (exp_dma ? 32'h44 : 32'h40)) begin
          n_err++;
          $display("FAIL contend_grant c=%0d: cpu_stall=%b dma_gnt=%b addr=%h, required %b %b %h",
                   c, bus.cpu_stall, bus.dma_gnt, bus.DMEMaddr, exp_dma, exp_dma,
                   exp_dma ? 32'h44 : 32'h40);
        end
        sb.push_back('{exp_dma, exp_dma ? 32'hA000_0011 : 32'hA000_0010});
      end
    end
  endtask

  task automatic test_dma_store();
    ret_t r;
    @(posedge clk); #1;
    set_dma(1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    n_cmp++;
    if (bus.dma_gnt !== 1'b1 || bus.DM_W !== 1'b1 || bus.DM_R !== 1'b0 ||
        bus.Data_in !== 32'h12345678 || bus.DMEMaddr !== 32'h20 || bus.SC !== 2'd0) begin
      n_err++;
      $display("FAIL dma_store_issue: gnt=%b DM_W=%b DM_R=%b Data_in=%h addr=%h SC=%0d, required 1 1 0 12345678 00000020 0",
               bus.dma_gnt, bus.DM_W, bus.DM_R, bus.Data_in, bus.DMEMaddr, bus.SC);
    end
    @(posedge clk); #1;
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL dma_store_no_rvalid: cpu_rvalid=%b dma_rvalid=%b, required 0 0",
               bus.cpu_rvalid, bus.dma_rvalid);
    end
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b0, 32'h20, 32'd0);
    sb.push_back('{1'b0, 32'h12345678});
    @(posedge clk); #1;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    r = sb.pop_front();
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== r.data) begin
      n_err++;
      $display("FAIL dma_store_readback: cpu_rvalid=%b cpu_rdata=%h, required 1 %h",
               bus.cpu_rvalid, bus.cpu_rdata, r.data);
    end
  endtask

  // 3 contended cycles, 1 cycle with DMA idle, then contention: the DMA must
  // wait a full 4 CPU grants again, so its grant lands in cycle 8.
  task automatic test_starve_restart();
    ret_t r;
    bit   exp_dma;
    logic dma_on;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0 || 1'b1) begin
        @(posedge clk); #1;
      end
      dma_on = (c != 3) && (c != 9);
      set_cpu(c != 9, 1'b0, 32'h48, 32'd0);
      set_dma(dma_on, 1'b0, 32'h4C, 32'd0);
      @(negedge clk);
      n_cmp++;
      if (sb.size() > 0) begin
        r = sb.pop_front();
        if (bus.cpu_rvalid !== !r.is_dma || bus.dma_rvalid !== r.is_dma ||
            (r.is_dma ? bus.dma_rdata : bus.cpu_rdata) !== r.data) begin
          n_err++;
          $display("FAIL restart_return c=%0d: cpu_rvalid=%b dma_rvalid=%b rdata=%h, required dma=%b data=%h",
                   c, bus.cpu_rvalid, bus.dma_rvalid, bus.cpu_rdata, r.is_dma, r.data);
        end
      end else if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
        n_err++;
        $display("FAIL restart_return c=%0d: cpu_rvalid=%b dma_rvalid=%b, required 0 0",
                 c, bus.cpu_rvalid, bus.dma_rvalid);
      end
      if (c < 9) begin
        exp_dma = (c == 8);
        n_cmp++;
        if (bus.dma_gnt !== exp_dma || bus.cpu_stall !== exp_dma) begin
          n_err++;
          $display("FAIL restart_grant c=%0d: dma_gnt=%b cpu_stall=%b, required %b %b",
                   c, bus.dma_gnt, bus.cpu_stall, exp_dma, exp_dma);
        end
        sb.push_back('{exp_dma, exp_dma ? 32'hA000_0013 : 32'hA000_0012});
      end
    end
  endtask

  task automatic test_reset_mid_read();
    ret_t r;
    @(posedge clk); #1;
    set_cpu(1'b1, 1'b0, 32'h10, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.CS !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_issue: CS=%b cpu_stall=%b, required 1 0", bus.CS, bus.cpu_stall);
    end
    sb.push_back('{1'b0, 32'hDEADBEEF});
    @(posedge clk); #1;
    reset = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h24, 32'd0);
    set_dma(1'b1, 1'b1, 32'h30, 32'h55AA55AA);
    @(negedge clk);
    r = sb.pop_front();
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== r.data) begin
      n_err++;
      $display("FAIL rstmid_return: cpu_rvalid=%b cpu_rdata=%h, required 1 %h",
               bus.cpu_rvalid, bus.cpu_rdata, r.data);
    end
    n_cmp++;
    if (bus.CS !== 1'b0 || bus.dma_gnt !== 1'b0 || bus.DM_W !== 1'b0 || bus.cpu_stall !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_nogrant: CS=%b dma_gnt=%b DM_W=%b cpu_stall=%b, required 0 0 0 1",
               bus.CS, bus.dma_gnt, bus.DM_W, bus.cpu_stall);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0 || mem[12] !== 32'hA000_000C) begin
      n_err++;
      $display("FAIL rstmid_after: cpu_rvalid=%b dma_rvalid=%b mem[0x30]=%h, required 0 0 a000000c",
               bus.cpu_rvalid, bus.dma_rvalid, mem[12]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + 32'(i);
    mem[4] = 32'hDEADBEEF;
    test_reset();
    test_cpu_load();
    test_contention();
    test_dma_store();
    test_starve_restart();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
